mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing one `mem_control` instance between the instruction-fetch unit (word reads only) and the load/store unit (byte/halfword/word reads and writes). Sits directly in front of `mem_control`: it serialises requests, issues them with the right sub-word access code, and routes read data back to the owner one cycle later. It also sequences the memory's two-cycle read-modify-write so neither requester has to hold write operands.

## Interface
- `MAX_LSU_BURST`, 4: consecutive LSU grants allowed while a fetch request is waiting; range 1..15.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rstn_i`  in  1  reset; asynchronous and active-low.
- `if_req_i`  in  1  fetch read request; held with `if_addr_i` until granted.
- `if_addr_i`  in  32  fetch address, word aligned.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch read data valid.
- `if_rdata_o`  out  32  fetch read data.
- `ls_req_i`  in  1  LSU request; held with its operands until granted.
- `ls_we_i`  in  1  1 = write, 0 = read.
- `ls_acc_i`  in  2  `MEM_ACCESS_*` code.
- `ls_sext_i`  in  1  sign-extend sub-word read.
- `ls_addr_i`  in  32  LSU address.
- `ls_wdata_i`  in  32  LSU write data, right-aligned.
- `ls_gnt_o`  out  1  LSU request accepted this cycle.
- `ls_rvalid_o`  out  1  LSU read data valid.
- `ls_rdata_o`  out  32  LSU read data, already extended.
- `ls_wdone_o`  out  1  LSU write committed this cycle.
- `mem_r_en_o`, `mem_acc_r_o` [2], `mem_sext_o`, `mem_addr_r_o` [32]  out  memory read port.
- `mem_data_r_i`  in  32  memory read data; valid the cycle after issue.
- `mem_wr_en_o`, `mem_acc_w_o` [2], `mem_addr_w_o` [32], `mem_data_w_o` [32]  out  memory write port.
- `mem_wr_ready_i`  in  1  memory able to accept a request (memory is in its READY state).

## Operation
- States:
  - `ST_IDLE`: grants allowed.
  - `ST_WPEND`: second cycle of a write; no grants.
- Reset enters `ST_IDLE`.
- In `ST_IDLE`, no grant is given while `mem_wr_ready_i` = 0. The memory also blocks reads in that case, which covers its post-reset cycle.
- Request transfer:
  - A transfer occurs on `req & gnt`. Grant is combinational from the requests in `ST_IDLE` with `mem_wr_ready_i` = 1.
  - At most one grant per cycle.
- Priority:
  - LSU wins by default.
  - A 4-bit streak counter increments on each LSU grant while `if_req_i` = 1.
  - When the streak equals `MAX_LSU_BURST` and `if_req_i` = 1, fetch wins.
  - The counter clears on any fetch grant, and whenever `if_req_i` = 0.
- Fetch or LSU read grant:
  - Drive `mem_r_en_o` = 1, with `mem_addr_r_o`, `mem_acc_r_o` and `mem_sext_o` taken from the winner.
  - Fetch uses WORD with sext 0.
  - Register `rd_owner` (fetch / LSU) and `rd_pend` = 1.
- Read response:
  - In the cycle after a read grant, the owner's `*_rvalid_o` = 1 and its `*_rdata_o` = `mem_data_r_i`.
  - The non-owner's `*_rdata_o` = 0.
  - Back-to-back reads are allowed, so a response and a new grant can occur in the same cycle.
- LSU write grant:
  - Drive `mem_wr_en_o` = 1 and the write port from the `ls_*` inputs.
  - Capture address, access code and data into registers.
  - Go to `ST_WPEND`.
- `ST_WPEND`:
  - Hold the write port from the captured registers, with `mem_wr_en_o` = 0.
  - Pulse `ls_wdone_o` = 1.
  - Return to `ST_IDLE`.
- Only the write port drives during a write. Read port outputs are 0 whenever no read is granted.
- Out-of-range addresses are passed through unchanged. The read response still fires, with data as returned by the memory.

## Timing
- Reset values: every output 0; state `ST_IDLE`; streak 0; `rd_pend` 0; capture registers 0.
- Read latency: grant in cycle N, `rvalid` in N+1. Throughput is one read per cycle.
- Write occupancy:
  - Grant in cycle N, `ls_wdone_o` in N+1.
  - The earliest next grant is N+2, subject to `mem_wr_ready_i`.
  - A read response owed from N-1 is still delivered in N, the same cycle as the write grant.
- Simultaneous requests with streak < `MAX_LSU_BURST`: LSU is granted and `if_gnt_o` stays 0.
- Asynchronous reset during `ST_WPEND` or with a read outstanding:
  - The operation is dropped.
  - No `rvalid` or `wdone` follows.
  - Outputs go to 0 immediately.
- A request deasserted before grant (protocol violation) is simply not serviced. No state is kept.

## Test plan
- Reset release, `if_req_i`=1, `if_addr_i`=0x0:
  - No grant while `mem_wr_ready_i`=0.
  - Grant in the first cycle `mem_wr_ready_i`=1.
  - `if_rvalid_o` the next cycle with the memory word.
- LSU halfword write 0xBEEF to 0x102 over old word 0x11223344:
  - `ls_gnt_o` then `ls_wdone_o`.
  - Write port held stable for 2 cycles.
  - A subsequent word read of 0x100 returns 0xBEEF3344.
- LSU signed byte read of 0x103 holding 0x80: `ls_rdata_o` = 0xFFFFFF80 one cycle after grant.
- Both requesters held high for 12 cycles with `MAX_LSU_BURST`=4: grant pattern LSU×4, IF, LSU×4, IF.
- Back-to-back fetch reads 0x0, 0x4, 0x8 followed by an LSU write:
  - `rvalid` on three consecutive cycles.
  - The write grant coincides with the last response, and that data is correct.
- `rstn_i` pulsed low during `ST_WPEND`: `ls_wdone_o` never asserts, and all outputs are 0 during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of mem_control: serialises fetch and LSU requests,
// routes read data back to its owner and sequences the two-cycle write.
module mem_arbiter #(
    parameter int unsigned MAX_LSU_BURST = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [1:0]  ls_acc_i,
    input  logic        ls_sext_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_wdone_o,
    output logic        mem_r_en_o,
    output logic [1:0]  mem_acc_r_o,
    output logic        mem_sext_o,
    output logic [31:0] mem_addr_r_o,
    input  logic [31:0] mem_data_r_i,
    output logic        mem_wr_en_o,
    output logic [1:0]  mem_acc_w_o,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_data_w_o,
    input  logic        mem_wr_ready_i
);

    localparam logic [1:0] MEM_ACCESS_WORD = 2'd2;
    localparam logic [3:0] BURST_LIMIT     = 4'(MAX_LSU_BURST);

    typedef enum logic {StIdle, StWpend} state_e;

    state_e      state_q;
    logic [3:0]  streak_q;
    logic        rd_pend_q;
    logic        rd_owner_q;  // 1 = LSU owns the outstanding read
    logic [31:0] w_addr_q;
    logic [1:0]  w_acc_q;
    logic [31:0] w_data_q;

    logic can_grant, if_win, ls_win, ls_rd_win, ls_wr_win;

    // Grants are gated by reset so every output is 0 while rstn_i is low.
    always_comb begin
        can_grant = rstn_i && (state_q == StIdle) && mem_wr_ready_i;
        if_win    = can_grant && if_req_i && (!ls_req_i || (streak_q == BURST_LIMIT));
        ls_win    = can_grant && ls_req_i && !if_win;
        ls_rd_win = ls_win && !ls_we_i;
        ls_wr_win = ls_win && ls_we_i;
    end

    always_comb begin
        if_gnt_o     = if_win;
        ls_gnt_o     = ls_win;
        mem_r_en_o   = 1'b0;
        mem_acc_r_o  = 2'd0;
        mem_sext_o   = 1'b0;
        mem_addr_r_o = 32'd0;
        mem_wr_en_o  = 1'b0;
        mem_acc_w_o  = 2'd0;
        mem_addr_w_o = 32'd0;
        mem_data_w_o = 32'd0;
        if (if_win) begin
            mem_r_en_o   = 1'b1;
            mem_acc_r_o  = MEM_ACCESS_WORD;
            mem_addr_r_o = if_addr_i;
        end else if (ls_rd_win) begin
            mem_r_en_o   = 1'b1;
            mem_acc_r_o  = ls_acc_i;
            mem_sext_o   = ls_sext_i;
            mem_addr_r_o = ls_addr_i;
        end
        if (ls_wr_win) begin
            mem_wr_en_o  = 1'b1;
            mem_acc_w_o  = ls_acc_i;
            mem_addr_w_o = ls_addr_i;
            mem_data_w_o = ls_wdata_i;
        end else if (state_q == StWpend) begin
            mem_acc_w_o  = w_acc_q;
            mem_addr_w_o = w_addr_q;
            mem_data_w_o = w_data_q;
        end
        if_rvalid_o = rd_pend_q && !rd_owner_q;
        ls_rvalid_o = rd_pend_q && rd_owner_q;
        if_rdata_o  = if_rvalid_o ? mem_data_r_i : 32'd0;
        ls_rdata_o  = ls_rvalid_o ? mem_data_r_i : 32'd0;
        ls_wdone_o  = (state_q == StWpend);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            streak_q   <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            w_addr_q   <= 32'd0;
            w_acc_q    <= 2'd0;
            w_data_q   <= 32'd0;
        end else begin
            rd_pend_q  <= if_win || ls_rd_win;
            rd_owner_q <= ls_rd_win;
            if (!if_req_i || if_win) begin
                streak_q <= 4'd0;
            end else if (ls_win) begin
                streak_q <= streak_q + 4'd1;
            end
            case (state_q)
                StIdle: begin
                    if (ls_wr_win) begin
                        state_q  <= StWpend;
                        w_addr_q <= ls_addr_i;
                        w_acc_q  <= ls_acc_i;
                        w_data_q <= ls_wdata_i;
                    end
                end
                StWpend: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural mem_control model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we, ls_sext;
    logic [1:0]  ls_acc;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid, ls_wdone;
    logic [31:0] ls_rdata;
    logic        mem_r_en, mem_sext, mem_wr_en, mem_ready;
    logic [1:0]  mem_acc_r, mem_acc_w;
    logic [31:0] mem_addr_r, mem_addr_w, mem_data_w;
    logic [31:0] mem_data_r;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_LSU_BURST(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_acc_i(ls_acc), .ls_sext_i(ls_sext),
        .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_wdone_o(ls_wdone),
        .mem_r_en_o(mem_r_en), .mem_acc_r_o(mem_acc_r), .mem_sext_o(mem_sext),
        .mem_addr_r_o(mem_addr_r), .mem_data_r_i(mem_data_r),
        .mem_wr_en_o(mem_wr_en), .mem_acc_w_o(mem_acc_w), .mem_addr_w_o(mem_addr_w),
        .mem_data_w_o(mem_data_w), .mem_wr_ready_i(mem_ready)
    );

    logic [171:0] all_out;
    assign all_out = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_wdone,
                      mem_r_en, mem_acc_r, mem_sext, mem_addr_r, mem_wr_en, mem_acc_w,
                      mem_addr_w, mem_data_w};

    // Memory model: read data one cycle after r_en, write committed in the
    // second cycle from the port values held by the arbiter.
    logic [31:0] mem [0:255];
    logic        loaded = 1'b0;
    logic        wsecond = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] acc,
                                           input logic s, input logic [31:0] wd);
        logic [7:0]  b;
        logic [15:0] h;
        b = wd[{a[1:0], 3'b000} +: 8];
        h = wd[{a[1], 4'b0000} +: 16];
        case (acc)
            2'd0:    return s ? {{24{b[7]}}, b} : {24'd0, b};
            2'd1:    return s ? {{16{h[15]}}, h} : {16'd0, h};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [1:0] acc, input logic [31:0] d);
        logic [31:0] w;
        w = old;
        case (acc)
            2'd0:    w[{a[1:0], 3'b000} +: 8] = d[7:0];
            2'd1:    w[{a[1], 4'b0000} +: 16] = d[15:0];
            default: w = d;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            mem[0]  <= 32'hDEADBEEF;
            mem[1]  <= 32'h01234567;
            mem[2]  <= 32'hCAFEF00D;
            mem[64] <= 32'h11223344;
            loaded  <= 1'b1;
        end
        if (mem_r_en) mem_data_r <= mem_rd(mem_addr_r, mem_acc_r, mem_sext, mem[mem_addr_r[9:2]]);
        if (wsecond) mem[mem_addr_w[9:2]] <= mem_merge(mem[mem_addr_w[9:2]], mem_addr_w,
                                                      mem_acc_w, mem_data_w);
        wsecond <= rstn && mem_wr_en;
    end

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++;
        if (all_out !== 172'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        mem_ready = 1'b0; rstn = 1'b1; #1;
        n_cmp++;
        if (if_gnt !== 1'b0) begin
            n_bad++; $display("FAIL not_ready_gnt0: got %b want 0", if_gnt);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (if_gnt !== 1'b0) begin
            n_bad++; $display("FAIL not_ready_gnt1: got %b want 0", if_gnt);
        end
        @(negedge clk);
        mem_ready = 1'b1; #1;
        n_cmp++;
        if ({if_gnt, ls_gnt, mem_r_en, mem_acc_r, mem_sext, mem_addr_r} !== {3'b101, 2'd2, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL first_fetch_gnt: got gnt=%b r_en=%b acc=%0d sext=%b addr=%h want 1 1 2 0 0",
                     if_gnt, mem_r_en, mem_acc_r, mem_sext, mem_addr_r);
        end
        @(negedge clk);
        if_req = 1'b0; #1;
        n_cmp++;
        if ({if_rvalid, if_rdata, ls_rvalid, ls_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL first_fetch_rsp: got v=%b d=%h lsv=%b lsd=%h want 1 deadbeef 0 0",
                     if_rvalid, if_rdata, ls_rvalid, ls_rdata);
        end
    endtask

    task automatic test_ls_write();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_acc = 2'd1; ls_addr = 32'h102; ls_wdata = 32'h0000BEEF; #1;
        n_cmp++;
        if ({ls_gnt, if_gnt, mem_wr_en, mem_acc_w, mem_addr_w, mem_data_w, mem_r_en}
            !== {3'b101, 2'd1, 32'h102, 32'hBEEF, 1'b0}) begin
            n_bad++;
            $display("FAIL half_write_gnt: got gnt=%b we=%b acc=%0d a=%h d=%h r_en=%b want 1 1 1 102 beef 0",
                     ls_gnt, mem_wr_en, mem_acc_w, mem_addr_w, mem_data_w, mem_r_en);
        end
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h4; #1;
        n_cmp++;
        if ({ls_wdone, ls_gnt, if_gnt, mem_wr_en, mem_acc_w, mem_addr_w, mem_data_w}
            !== {4'b1000, 2'd1, 32'h102, 32'hBEEF}) begin
            n_bad++;
            $display("FAIL half_write_hold: got done=%b gnt=%b/%b we=%b acc=%0d a=%h d=%h want 1 0/0 0 1 102 beef",
                     ls_wdone, ls_gnt, if_gnt, mem_wr_en, mem_acc_w, mem_addr_w, mem_data_w);
        end
        @(negedge clk);
        if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_acc = 2'd2; ls_sext = 1'b0; ls_addr = 32'h100; #1;
        n_cmp++;
        if ({ls_wdone, ls_gnt, mem_r_en, mem_wr_en, mem_addr_r} !== {4'b0110, 32'h100}) begin
            n_bad++;
            $display("FAIL readback_gnt: got done=%b gnt=%b r_en=%b we=%b a=%h want 0 1 1 0 100",
                     ls_wdone, ls_gnt, mem_r_en, mem_wr_en, mem_addr_r);
        end
        @(negedge clk);
        ls_req = 1'b0; #1;
        n_cmp++;
        if ({ls_rvalid, ls_rdata, if_rvalid, if_rdata} !== {1'b1, 32'hBEEF3344, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL readback_data: got v=%b d=%h ifv=%b ifd=%h want 1 beef3344 0 0",
                     ls_rvalid, ls_rdata, if_rvalid, if_rdata);
        end
    endtask

    task automatic test_signed_byte();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_acc = 2'd0; ls_addr = 32'h103; ls_wdata = 32'h80; #1;
        n_cmp++;
        if ({ls_gnt, mem_wr_en, mem_acc_w, mem_data_w} !== {2'b11, 2'd0, 32'h80}) begin
            n_bad++;
            $display("FAIL byte_write_gnt: got gnt=%b we=%b acc=%0d d=%h want 1 1 0 80",
                     ls_gnt, mem_wr_en, mem_acc_w, mem_data_w);
        end
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_acc = 2'd0; ls_sext = 1'b1; ls_addr = 32'h103; #1;
        n_cmp++;
        if ({ls_gnt, mem_r_en, mem_acc_r, mem_sext, mem_addr_r} !== {2'b11, 2'd0, 1'b1, 32'h103}) begin
            n_bad++;
            $display("FAIL sbyte_read_gnt: got gnt=%b r_en=%b acc=%0d sext=%b a=%h want 1 1 0 1 103",
                     ls_gnt, mem_r_en, mem_acc_r, mem_sext, mem_addr_r);
        end
        @(negedge clk);
        ls_req = 1'b0; ls_sext = 1'b0; #1;
        n_cmp++;
        if ({ls_rvalid, ls_rdata} !== {1'b1, 32'hFFFFFF80}) begin
            n_bad++;
            $display("FAIL sbyte_read_data: got v=%b d=%h want 1 ffffff80", ls_rvalid, ls_rdata);
        end
    endtask

    task automatic test_priority();
        logic [11:0] pat;
        pat = 12'b0010_0001_0000;  // fetch wins in cycles 4 and 9
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_acc = 2'd2; ls_addr = 32'h0;
        if_req = 1'b1; if_addr = 32'h4;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({if_gnt, ls_gnt} !== {pat[i], ~pat[i]}) begin
                n_bad++;
                $display("FAIL prio_gnt[%0d]: got if=%b ls=%b want if=%b ls=%b",
                         i, if_gnt, ls_gnt, pat[i], ~pat[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if ({if_rvalid, ls_rvalid, ls_rdata} !== {pat[i-1], ~pat[i-1],
                                                         pat[i-1] ? 32'h0 : 32'hDEADBEEF}) begin
                    n_bad++;
                    $display("FAIL prio_rsp[%0d]: got ifv=%b lsv=%b lsd=%h want ifv=%b",
                             i, if_rvalid, ls_rvalid, ls_rdata, pat[i-1]);
                end
            end
        end
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b0; #1;
        n_cmp++;
        if ({if_gnt, ls_gnt, ls_rvalid, ls_rdata} !== {3'b001, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL prio_drain: got gnt=%b/%b lsv=%b lsd=%h want 0/0 1 deadbeef",
                     if_gnt, ls_gnt, ls_rvalid, ls_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [0:2];
        exp_d[0] = 32'hDEADBEEF; exp_d[1] = 32'h01234567; exp_d[2] = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'(i * 4); #1;
            n_cmp++;
            if ({if_gnt, mem_addr_r} !== {1'b1, 32'(i * 4)}) begin
                n_bad++;
                $display("FAIL b2b_gnt[%0d]: got gnt=%b a=%h want 1 %h", i, if_gnt, mem_addr_r, i * 4);
            end
            if (i > 0) begin
                n_cmp++;
                if ({if_rvalid, if_rdata} !== {1'b1, exp_d[i-1]}) begin
                    n_bad++;
                    $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want 1 %h", i - 1, if_rvalid, if_rdata, exp_d[i-1]);
                end
            end
        end
        @(negedge clk);
        if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_acc = 2'd2; ls_addr = 32'h10; ls_wdata = 32'h55AA55AA; #1;
        n_cmp++;
        if ({ls_gnt, mem_wr_en, mem_r_en, if_rvalid, if_rdata} !== {4'b1101, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL b2b_write_rsp: got gnt=%b we=%b r_en=%b v=%b d=%h want 1 1 0 1 cafef00d",
                     ls_gnt, mem_wr_en, mem_r_en, if_rvalid, if_rdata);
        end
        @(negedge clk);
        ls_req = 1'b0; #1;
        n_cmp++;
        if ({ls_wdone, if_rvalid, mem_r_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_wdone: got done=%b v=%b r_en=%b want 1 0 0", ls_wdone, if_rvalid, mem_r_en);
        end
    endtask

    task automatic test_reset_wpend();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_acc = 2'd2; ls_addr = 32'h14; ls_wdata = 32'h12345678; #1;
        n_cmp++;
        if (ls_gnt !== 1'b1) begin
            n_bad++; $display("FAIL rst_wr_gnt: got %b want 1", ls_gnt);
        end
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h0; #1;
        rstn = 1'b0; #1;
        n_cmp++;
        if (all_out !== 172'd0) begin
            n_bad++; $display("FAIL rst_wpend_outputs: got %h want 0", all_out);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (all_out !== 172'd0) begin
            n_bad++; $display("FAIL rst_hold_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        if_req = 1'b0; rstn = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            n_cmp++;
            if ({ls_wdone, mem_wr_en, ls_rvalid, if_rvalid} !== 4'b0000) begin
                n_bad++;
                $display("FAIL rst_after[%0d]: got done=%b we=%b lsv=%b ifv=%b want 0 0 0 0",
                         i, ls_wdone, mem_wr_en, ls_rvalid, if_rvalid);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; mem_ready = 1'b1;
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_acc = 2'd0; ls_sext = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0;
        test_reset();
        test_ls_write();
        test_signed_byte();
        test_priority();
        test_back_to_back();
        test_reset_wpend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
